// File: rtl/sram_1rw_requester.sv
`default_nettype none
// ============================================================================
// Module   : sram_1rw_requester
// Purpose  : Initiator-side controller for the RW0_* port of a 1RW SRAM
//            wrapper. Turns a valid/ready request stream into SRAM accesses
//            and returns read data in order through a small response FIFO.
//            Read acceptance is credit-limited so the FIFO can never overflow.
// Optional : SRAM_REQ_ZERO_INIT_EN - when defined, the array is swept with
//            zero writes after reset before any request is accepted.
// Ports    : clock/reset          - clock, async active-high reset
//            req_*                - request stream (write/addr/wdata)
//            resp_*               - in-order read response stream
//            init_done            - array ready for traffic
//            RW0_*                - SRAM macro port (rdata valid 1 cycle
//                                   after a read enable)
// Revision : 1.0 - initial release
// ============================================================================
module sram_1rw_requester #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 64,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              RW0_clk,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  // Holds occupancy plus one in-flight read (up to RESP_DEPTH+1).
  localparam int CNT_W = $clog2(RESP_DEPTH + 2);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(RESP_DEPTH - 1);

  logic              w_run;
  logic              w_init_active;
  logic [ADDR_W-1:0] w_init_addr;

`ifdef SRAM_REQ_ZERO_INIT_EN
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [ADDR_W-1:0] w_init_cnt_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_run          = 1'b0;
    w_init_active  = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_active  = 1'b1;
        w_init_cnt_nxt = r_init_cnt + ADDR_W'(1);
        if (r_init_cnt == '1) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign w_init_addr = r_init_cnt;
  assign init_done   = w_run;
`else
  assign w_run         = 1'b1;
  assign w_init_active = 1'b0;
  assign w_init_addr   = '0;
  assign init_done     = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Response FIFO and read credits
  // --------------------------------------------------------------------------
  logic              r_rd_inflight;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_mem [RESP_DEPTH];

  logic              w_pop;
  logic [CNT_W-1:0]  w_credits;
  logic              w_rd_credit;
  logic              w_accept;
  logic              w_rd_accept;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign resp_valid = (r_count != '0);
  assign resp_rdata = r_mem[r_rd_ptr];
  assign w_pop      = resp_valid & resp_ready;

  // A read is allowed at full credit if a slot is freed this same cycle.
  assign w_credits   = r_count + CNT_W'(r_rd_inflight);
  assign w_rd_credit = (w_credits < C_DEPTH) || ((w_credits == C_DEPTH) && w_pop);

  assign req_ready   = ~reset & w_run & (req_write | w_rd_credit);
  assign w_accept    = req_valid & req_ready;
  assign w_rd_accept = w_accept & ~req_write;

  // SRAM drive is combinational; reset gating makes RW0_en drop immediately.
  assign RW0_clk   = clock;
  assign RW0_en    = ~reset & (w_init_active | w_accept);
  assign RW0_wmode = ~reset & (w_init_active | req_write);
  assign RW0_addr  = reset ? '0 : (w_init_active ? w_init_addr : req_addr);
  assign RW0_wdata = (reset | w_init_active) ? '0 : req_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_inflight <= 1'b0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_rd_inflight <= w_rd_accept;
      // The SRAM presents read data the cycle after the enable.
      if (r_rd_inflight) begin
        r_mem[r_wr_ptr] <= RW0_rdata;
        r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      case ({r_rd_inflight, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_1rw_requester
// Purpose  : Self-checking bench for sram_1rw_requester (ADDR_W=4). A simple
//            1RW SRAM model sits on the RW0_* port; a transaction-level
//            reference (memory image + queue of outstanding reads stamped
//            with their acceptance cycle) predicts ready/valid/data.
//            SRAM_REQ_ZERO_INIT_EN selects the init-sweep checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_1rw_requester;

  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 2;
`ifdef SRAM_REQ_ZERO_INIT_EN
  localparam logic C_INIT_RST = 1'b0;
`else
  localparam logic C_INIT_RST = 1'b1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic          RW0_clk;
  logic          RW0_en;
  logic          RW0_wmode;
  logic [AW-1:0] RW0_addr;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata = '0;

  sram_1rw_requester #(.ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .RW0_clk(RW0_clk), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_addr(RW0_addr), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural SRAM macro: synchronous write, registered read.
  logic [DW-1:0] sram [2**AW];
  always @(posedge RW0_clk) begin
    if (RW0_en) begin
      if (RW0_wmode) sram[RW0_addr] = RW0_wdata;
      else           RW0_rdata <= sram[RW0_addr];
    end
  end

  // Reference model state.
  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          q[$];
  logic [DW-1:0] ref_mem [2**AW];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One RUN-mode cycle: starts just after a negedge, ends at the next one.
  task automatic cycle(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr, output logic acc);
    logic exp_rv, exp_pop, exp_rdy;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; resp_ready = rr;
    #2;
    exp_rv  = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
    exp_pop = exp_rv && rr;
    exp_rdy = w ? 1'b1 : ((q.size() < DEPTH) || ((q.size() == DEPTH) && exp_pop));
    chk("init_done", DW'(init_done), DW'(1'b1));
    chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    chk("resp_valid", DW'(resp_valid), DW'(exp_rv));
    if (exp_rv) chk("resp_rdata", resp_rdata, q[0].data);
    acc = v && exp_rdy;
    chk("rw0_en", DW'(RW0_en), DW'(acc));
    if (acc) begin
      chk("rw0_wmode", DW'(RW0_wmode), DW'(w));
      chk("rw0_addr", DW'(RW0_addr), DW'(a));
      if (w) chk("rw0_wdata", RW0_wdata, d);
    end
    if (exp_pop) void'(q.pop_front());
    if (acc) begin
      if (w) ref_mem[a] = d;
      else   q.push_back('{cyc, ref_mem[a]});
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, rr, acc);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    cycle(1'b1, 1'b1, a, d, 1'b1, acc);
  endtask

`ifdef SRAM_REQ_ZERO_INIT_EN
  // Post-reset zero sweep; starts right after reset release at a negedge.
  task automatic init_sweep();
    req_valid = 1'b1; req_write = 1'b0; req_addr = '0;
    for (int i = 0; i < 2**AW; i++) begin
      #2;
      chk("sweep_init_done", DW'(init_done), '0);
      chk("sweep_req_ready", DW'(req_ready), '0);
      chk("sweep_en", DW'(RW0_en), DW'(1'b1));
      chk("sweep_wmode", DW'(RW0_wmode), DW'(1'b1));
      chk("sweep_wdata", RW0_wdata, '0);
      chk("sweep_addr", DW'(RW0_addr), DW'(i));
      @(negedge clock);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;
  endtask
`endif

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, DW'(req_ready), '0);
    chk({tag, "_resp_valid"}, DW'(resp_valid), '0);
    chk({tag, "_resp_rdata"}, resp_rdata, '0);
    chk({tag, "_init_done"}, DW'(init_done), DW'(C_INIT_RST));
    chk({tag, "_en"}, DW'(RW0_en), '0);
    chk({tag, "_wmode"}, DW'(RW0_wmode), '0);
    chk({tag, "_addr"}, DW'(RW0_addr), '0);
    chk({tag, "_wdata"}, RW0_wdata, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    for (int i = 0; i < 2**AW; i++) begin
      sram[i] = {$urandom(), $urandom()};
      ref_mem[i] = 'x;
    end

    // Reset state.
    @(negedge clock);
    #2;
    check_reset_outputs("rst");
    @(negedge clock);
    reset = 1'b0;

`ifdef SRAM_REQ_ZERO_INIT_EN
    init_sweep();
`else
    for (int i = 0; i < 2**AW; i++) wr(AW'(i), {$urandom(), $urandom()});
`endif

    // Read after init / image established.
    cycle(1'b1, 1'b0, 4'd9, '0, 1'b1, acc);
    idle(3, 1'b1);

    // Write then immediately read the same address.
    wr(4'd3, 64'hDEADBEEF_CAFEF00D);
    cycle(1'b1, 1'b0, 4'd3, '0, 1'b1, acc);
    idle(3, 1'b1);

    // Credit limit: third read stalls until the consumer drains.
    wr(4'd1, 64'h11); wr(4'd2, 64'h22); wr(4'd3, 64'h33);
    cycle(1'b1, 1'b0, 4'd1, '0, 1'b0, acc);
    cycle(1'b1, 1'b0, 4'd2, '0, 1'b0, acc);
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) cycle(1'b1, 1'b0, 4'd3, '0, k >= 3, acc);
    idle(4, 1'b1);

    // Back-to-back reads at full rate.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, AW'(i), '0, 1'b1, acc);
    idle(4, 1'b1);

    // Writes while the response buffer is full.
    cycle(1'b1, 1'b0, 4'd1, '0, 1'b0, acc);
    cycle(1'b1, 1'b0, 4'd2, '0, 1'b0, acc);
    for (int i = 10; i < 14; i++) cycle(1'b1, 1'b1, AW'(i), {$urandom(), $urandom()}, 1'b0, acc);
    idle(4, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom() % 4) != 0, ($urandom() % 3) == 0, AW'($urandom()),
            {$urandom(), $urandom()}, ($urandom() % 4) != 0, acc);
    end
    idle(4, 1'b1);

    // Reset with one read buffered and one in flight.
    cycle(1'b1, 1'b0, 4'd5, '0, 1'b0, acc);
    cycle(1'b1, 1'b0, 4'd6, '0, 1'b0, acc);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    @(negedge clock);
    reset = 1'b0;
`ifdef SRAM_REQ_ZERO_INIT_EN
    init_sweep();
`endif
    idle(6, 1'b1);
    cycle(1'b1, 1'b0, 4'd7, '0, 1'b1, acc);
    idle(3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
